// File: rtl/alu_core_pkg.sv
// alu_core_pkg: shared definitions for the ALU execution stage.
//   ALU_WIDTH    default datapath width
//   alu_op_e     3-bit operation codes (OP_ADD..OP_MUL)
//   F_Z..F_V     bit positions inside the 4-bit flag word {Z,N,C,V}
//   mul_state_e  states of the sequential multiplier
package alu_core_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_e;

    localparam int unsigned F_Z = 3;
    localparam int unsigned F_N = 2;
    localparam int unsigned F_C = 1;
    localparam int unsigned F_V = 0;

    typedef enum logic [1:0] {
        MUL_IDLE,
        MUL_RUN,
        MUL_DONE
    } mul_state_e;

endpackage

// File: rtl/alu_core_if.sv
// alu_core_if: operand/control bus between the control unit and the ALU stage.
//   a, b, op         operands and operation code
//   la, lb, lf       load strobes for reg_a, reg_b and the flag register
//   result           combinational ALU result
//   reg_a, reg_b     accumulator registers
//   flags            registered {Z,N,C,V}
//   busy, done       multiplier handshake
// Modports: master drives operands/strobes, slave is the ALU stage.
interface alu_core_if #(
    parameter int unsigned WIDTH = 8
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             la;
    logic             lb;
    logic             lf;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] reg_a;
    logic [WIDTH-1:0] reg_b;
    logic [3:0]       flags;
    logic             busy;
    logic             done;

    modport master (
        output a, b, op, la, lb, lf,
        input  result, reg_a, reg_b, flags, busy, done
    );

    modport slave (
        input  a, b, op, la, lb, lf,
        output result, reg_a, reg_b, flags, busy, done
    );

endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: sequential shift-add multiplier, one partial product per cycle.
//   clk, rst_n   clock, asynchronous active-low reset
//   start        accepted only in IDLE; latches a and b
//   a, b         WIDTH-bit unsigned operands
//   busy         high while the WIDTH shift-add steps run
//   done         high for the single DONE cycle; product is valid then
//   product      2*WIDTH-bit unsigned product
module alu_mul_seq
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    mul_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    state_d = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                done    = 1'b1;
                state_d = MUL_IDLE;
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Multiplicand shifts left while the multiplier shifts right; its LSB
    // decides whether the current multiplicand is accumulated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else if (state_q == MUL_IDLE && start) begin
            cnt_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
            prod_q   <= '0;
        end else if (state_q == MUL_RUN) begin
            if (mplier_q[0]) begin
                prod_q <= prod_q + mcand_q;
            end
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CW'(1);
        end
    end

    assign product = prod_q;

endmodule

// File: rtl/alu_core.sv
// alu_core: ALU execution stage with accumulators A/B and a registered flag word.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          alu_core_if.slave: a, b, op, la, lb, lf in;
//                result, reg_a, reg_b, flags {Z,N,C,V}, busy, done out
// Build option: define ALU_MUL_EN to include the sequential multiplier (op 111).
// Without it, op 111 is a NOP with result 0 and busy/done held low.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_core_if.slave    bus
);

    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [3:0]         alu_flags;
    logic               alu_ld;

    logic [WIDTH-1:0]   reg_a_q;
    logic [WIDTH-1:0]   reg_b_q;
    logic [3:0]         flags_q;

    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [3:0]         mul_flags;

    always_comb begin
        wide    = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_op_e'(bus.op))
            OP_ADD: begin
                wide    = {1'b0, bus.a} + {1'b0, bus.b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra MSB of the zero-extended difference is the borrow (a < b).
                wide    = {1'b0, bus.a} - {1'b0, bus.b};
                alu_res = wide[WIDTH-1:0];
                alu_c   = wide[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SHL: begin
                alu_res = {bus.a[WIDTH-2:0], 1'b0};
                alu_c   = bus.a[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, bus.a[WIDTH-1:1]};
                alu_c   = bus.a[0];
            end
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        alu_flags      = '0;
        alu_flags[F_Z] = (alu_res == '0);
        alu_flags[F_N] = alu_res[WIDTH-1];
        alu_flags[F_C] = alu_c;
        alu_flags[F_V] = alu_v;
    end

    always_comb begin
        mul_flags      = '0;
        mul_flags[F_Z] = (mul_product == '0);
        mul_flags[F_N] = mul_product[2*WIDTH-1];
        mul_flags[F_C] = |mul_product[2*WIDTH-1:WIDTH];
    end

`ifdef ALU_MUL_EN
    logic mul_start;

    assign mul_start = (alu_op_e'(bus.op) == OP_MUL) && (bus.la || bus.lb || bus.lf);

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (bus.a),
        .b       (bus.b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    // Ordinary loads are blocked for the whole multiply, including the DONE
    // cycle where the product owns the register write ports.
    assign alu_ld = !mul_busy && !mul_done && (alu_op_e'(bus.op) != OP_MUL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a_q <= '0;
            reg_b_q <= '0;
            flags_q <= '0;
        end else if (mul_done) begin
            reg_a_q <= mul_product[WIDTH-1:0];
            reg_b_q <= mul_product[2*WIDTH-1:WIDTH];
            flags_q <= mul_flags;
        end else if (alu_ld) begin
            if (bus.la) begin
                reg_a_q <= alu_res;
            end
            if (bus.lb) begin
                reg_b_q <= alu_res;
            end
            if (bus.lf) begin
                flags_q <= alu_flags;
            end
        end
    end

    assign bus.result = alu_res;
    assign bus.reg_a  = reg_a_q;
    assign bus.reg_b  = reg_b_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = mul_busy;
    assign bus.done   = mul_done;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: self-checking bench for alu_core with an arithmetic reference model.
// Multiplier scenarios are compiled in when ALU_MUL_EN is defined.
module tb_alu_core;

    localparam int unsigned W = 8;

    logic clk;
    logic rst_n;

    int tests;
    int fails;

    // Shadow state of the architectural registers.
    int         exp_a;
    int         exp_b;
    logic [3:0] exp_f;

    alu_core_if #(.WIDTH(W)) bus ();

    alu_core #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int to_signed(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Reference: result and flags from plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b,
                                  output int res, output logic [3:0] f);
        int s;
        int ss;
        int c;
        int v;
        c = 0;
        v = 0;
        res = 0;
        case (op)
            0: begin
                s = a + b; res = s % 256; c = (s > 255) ? 1 : 0;
                ss = to_signed(a) + to_signed(b); v = (ss > 127 || ss < -128) ? 1 : 0;
            end
            1: begin
                s = a - b; res = (s + 256) % 256; c = (a < b) ? 1 : 0;
                ss = to_signed(a) - to_signed(b); v = (ss > 127 || ss < -128) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
            6: begin res = a / 2; c = a % 2; end
            default: res = 0;
        endcase
        f = {res == 0, res >= 128, c != 0, v != 0};
    endfunction

    task automatic drive(input int op, input int a, input int b,
                         input bit la, input bit lb, input bit lf);
        bus.op = op[2:0];
        bus.a  = a[7:0];
        bus.b  = b[7:0];
        bus.la = la;
        bus.lb = lb;
        bus.lf = lf;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        tests++;
        if (bus.reg_a !== 8'h00 || bus.reg_b !== 8'h00 || bus.flags !== 4'b0000 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL reset: reg_a=%h reg_b=%h flags=%b busy=%b done=%b, required 00 00 0000 0 0",
                     bus.reg_a, bus.reg_b, bus.flags, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests++;
        if (bus.reg_a !== 8'h00 || bus.reg_b !== 8'h00 || bus.flags !== 4'b0000 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: reg_a=%h reg_b=%h flags=%b busy=%b, required 00 00 0000 0",
                     bus.reg_a, bus.reg_b, bus.flags, bus.busy);
        end
        exp_a = 0;
        exp_b = 0;
        exp_f = 4'b0000;
    endtask

    task automatic test_directed();
        drive(0, 8'h7F, 8'h01, 1, 0, 1);
        tick();
        tests++;
        if (bus.reg_a !== 8'h80 || bus.flags !== 4'b0101) begin
            fails++;
            $display("FAIL add_ovf: reg_a=%h flags=%b, required 80 0101", bus.reg_a, bus.flags);
        end
        drive(1, 8'h03, 8'h05, 0, 1, 1);
        tick();
        tests++;
        if (bus.reg_b !== 8'hFE || bus.flags !== 4'b0110 || bus.reg_a !== 8'h80) begin
            fails++;
            $display("FAIL sub_borrow: reg_b=%h flags=%b reg_a=%h, required FE 0110 80",
                     bus.reg_b, bus.flags, bus.reg_a);
        end
        drive(0, 8'hFF, 8'h01, 1, 0, 0);
        tick();
        tests++;
        if (bus.reg_a !== 8'h00 || bus.flags !== 4'b0110) begin
            fails++;
            $display("FAIL add_noflags: reg_a=%h flags=%b, required 00 0110", bus.reg_a, bus.flags);
        end
        drive(6, 8'h01, 8'h00, 1, 0, 1);
        tick();
        tests++;
        if (bus.reg_a !== 8'h00 || bus.flags !== 4'b1010) begin
            fails++;
            $display("FAIL shr_zero: reg_a=%h flags=%b, required 00 1010", bus.reg_a, bus.flags);
        end
        drive(5, 8'h81, 8'h00, 1, 1, 1);
        tick();
        tests++;
        if (bus.reg_a !== 8'h02 || bus.reg_b !== 8'h02 || bus.flags !== 4'b0010) begin
            fails++;
            $display("FAIL shl_both: reg_a=%h reg_b=%h flags=%b, required 02 02 0010",
                     bus.reg_a, bus.reg_b, bus.flags);
        end
        exp_a = 8'h02;
        exp_b = 8'h02;
        exp_f = 4'b0010;
    endtask

    task automatic test_random_alu();
        int a;
        int b;
        int op;
        int res;
        logic [3:0] f;
        bit la;
        bit lb;
        bit lf;
        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 4))
                0: a = 8'h00;
                1: a = 8'h7F;
                2: a = 8'h80;
                3: a = 8'hFF;
                default: a = $urandom_range(0, 255);
            endcase
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 255);
            op = $urandom_range(0, 6);
            la = 1'($urandom_range(0, 1));
            lb = 1'($urandom_range(0, 1));
            lf = 1'($urandom_range(0, 1));
            drive(op, a, b, la, lb, lf);
            model(op, a, b, res, f);
            #1;
            tests++;
            if (bus.result !== res[7:0]) begin
                fails++;
                $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h got %h, required %h",
                         i, op, a, b, bus.result, res[7:0]);
            end
            if (la) exp_a = res;
            if (lb) exp_b = res;
            if (lf) exp_f = f;
            tick();
            tests++;
            if (bus.reg_a !== exp_a[7:0] || bus.reg_b !== exp_b[7:0] || bus.flags !== exp_f) begin
                fails++;
                $display("FAIL rand_regs[%0d]: op=%0d a=%h b=%h got %h %h %b, required %h %h %b",
                         i, op, a, b, bus.reg_a, bus.reg_b, bus.flags, exp_a[7:0], exp_b[7:0], exp_f);
            end
        end
    endtask

`ifdef ALU_MUL_EN
    task automatic run_mul(input int a, input int b);
        int p;
        int n;
        int done_at;
        logic [3:0] f;
        p = a * b;
        f = {p == 0, p >= 32768, (p / 256) != 0, 1'b0};
        drive(7, a, b, 1, 1, 1);
        #1;
        tests++;
        if (bus.result !== 8'h00) begin
            fails++;
            $display("FAIL mul_result_zero: got %h, required 00", bus.result);
        end
        tick();
        tests++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL mul_busy_start: busy=%b, required 1", bus.busy);
        end
        done_at = 0;
        n = 0;
        while (n < 20 && done_at == 0) begin
            if (bus.busy) begin
                // Noise while busy must be ignored.
                drive($urandom_range(0, 6), $urandom_range(0, 255), $urandom_range(0, 255), 1, 1, 1);
            end else begin
                drive(0, 0, 0, 0, 0, 0);
            end
            tick();
            n++;
            if (bus.done === 1'b1) done_at = n;
            if (done_at == 0 && (bus.reg_a !== exp_a[7:0] || bus.reg_b !== exp_b[7:0])) begin
                tests++;
                fails++;
                $display("FAIL mul_early_write: edge %0d reg_a=%h reg_b=%h, required %h %h",
                         n, bus.reg_a, bus.reg_b, exp_a[7:0], exp_b[7:0]);
            end
        end
        drive(0, 0, 0, 0, 0, 0);
        tests++;
        if (done_at != W) begin
            fails++;
            $display("FAIL mul_done_latency: done seen at edge %0d, required %0d", done_at, W);
        end
        tick();
        exp_a = p % 256;
        exp_b = p / 256;
        exp_f = f;
        tests++;
        if (bus.reg_a !== exp_a[7:0] || bus.reg_b !== exp_b[7:0] || bus.flags !== exp_f ||
            bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL mul_commit: %h*%h got %h %h %b done=%b busy=%b, required %h %h %b 0 0",
                     a[7:0], b[7:0], bus.reg_a, bus.reg_b, bus.flags, bus.done, bus.busy,
                     exp_a[7:0], exp_b[7:0], exp_f);
        end
    endtask

    task automatic test_mul();
        run_mul(8'h0F, 8'h11);
        run_mul(8'hFF, 8'hFF);
        run_mul(8'h00, 8'h9C);
        for (int i = 0; i < 4; i++) begin
            run_mul($urandom_range(0, 255), $urandom_range(0, 255));
        end
    endtask

    task automatic test_mul_reset();
        bit seen_done;
        drive(7, 8'hAB, 8'hCD, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.reg_a !== 8'h00 || bus.reg_b !== 8'h00 || bus.flags !== 4'b0000 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL mul_reset: reg_a=%h reg_b=%h flags=%b busy=%b done=%b, required 00 00 0000 0 0",
                     bus.reg_a, bus.reg_b, bus.flags, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
        end
        tests++;
        if (seen_done || bus.reg_a !== 8'h00 || bus.reg_b !== 8'h00) begin
            fails++;
            $display("FAIL mul_reset_after: activity=%b reg_a=%h reg_b=%h, required 0 00 00",
                     seen_done, bus.reg_a, bus.reg_b);
        end
        exp_a = 0;
        exp_b = 0;
        exp_f = 4'b0000;
    endtask
`else
    task automatic test_nop();
        bit active;
        active = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(7, $urandom_range(0, 255), $urandom_range(1, 255), 1, 1, 1);
            #1;
            tests++;
            if (bus.result !== 8'h00) begin
                fails++;
                $display("FAIL nop_result[%0d]: got %h, required 00", i, bus.result);
            end
            tick();
            if (bus.busy !== 1'b0 || bus.done !== 1'b0) active = 1'b1;
            tests++;
            if (bus.reg_a !== exp_a[7:0] || bus.reg_b !== exp_b[7:0] || bus.flags !== exp_f) begin
                fails++;
                $display("FAIL nop_regs[%0d]: got %h %h %b, required %h %h %b",
                         i, bus.reg_a, bus.reg_b, bus.flags, exp_a[7:0], exp_b[7:0], exp_f);
            end
        end
        tests++;
        if (active) begin
            fails++;
            $display("FAIL nop_handshake: busy/done asserted=%b, required 0", active);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_random_alu();
`ifdef ALU_MUL_EN
        test_mul();
        test_random_alu();
        test_mul_reset();
`else
        test_nop();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
